multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl_pkg.sv | 62 ++++++
 rtl/multi_cycle_ctrl_if.sv | 39 +++
 rtl/multi_cycle_ctrl_decode.sv | 91 +++++++++
 rtl/multi_cycle_ctrl.sv | 70 +++++++
 tb/tb_multi_cycle_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller and the datapath it steers:
// state codes, opcodes and the ALU/PC mux select values.
package multi_cycle_ctrl_pkg;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MADDR  = 4'd2;
    localparam logic [3:0] ST_MREAD  = 4'd3;
    localparam logic [3:0] ST_MWB    = 4'd4;
    localparam logic [3:0] ST_MWRITE = 4'd5;
    localparam logic [3:0] ST_REXE   = 4'd6;
    localparam logic [3:0] ST_RWB    = 4'd7;
    localparam logic [3:0] ST_BEQ    = 4'd8;
    localparam logic [3:0] ST_JMP    = 4'd9;
    localparam logic [3:0] ST_IEXE   = 4'd10;
    localparam logic [3:0] ST_IWB    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_load;
        logic       ir_load;
        logic       mdr_load;
        logic       ab_load;
        logic       aluout_load;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. The controller is the master: it reads
// instruction fields and status flags and drives every load, select and request.
interface multi_cycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_rdy;
    logic       pc_load;
    logic       ir_load;
    logic       mdr_load;
    logic       ab_load;
    logic       aluout_load;
    logic       IorD;
    logic       mem_rd;
    logic       mem_wr;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_rdy,
        output pc_load, ir_load, mdr_load, ab_load, aluout_load, IorD,
               mem_rd, mem_wr, RegWrite, RegDst, MemtoReg, ALUSrcA,
               ALUSrcB, ALUOp, PCSource, illegal, state
    );

    modport slave (
        output opcode, funct, zero, mem_rdy,
        input  pc_load, ir_load, mdr_load, ab_load, aluout_load, IorD,
               mem_rd, mem_wr, RegWrite, RegDst, MemtoReg, ALUSrcA,
               ALUSrcB, ALUOp, PCSource, illegal, state
    );
endinterface

// File: rtl/multi_cycle_ctrl_decode.sv
// Per-state output decode for the multi-cycle controller. Mostly Moore; the few
// handshake-qualified loads (mem_rdy, zero) and the illegal flag are gated here.
module ctrl_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic       mem_rdy,
    input  logic       zero,
    input  logic       rst,
    output ctrl_t      ctrl
);

    ctrl_t raw;

    always_comb begin
        raw = '0;
        case (state)
            ST_FETCH: begin
                raw.mem_rd    = 1'b1;
                raw.alu_src_b = SRCB_FOUR;
                raw.ir_load   = mem_rdy;
                raw.pc_load   = mem_rdy;
            end
            ST_DECODE: begin
                raw.ab_load     = 1'b1;
                raw.aluout_load = 1'b1;
                raw.alu_src_b   = SRCB_IMM_SH;
                raw.illegal     = !op_supported(opcode);
            end
            ST_MADDR: begin
                raw.alu_src_a   = 1'b1;
                raw.alu_src_b   = SRCB_IMM;
                raw.aluout_load = 1'b1;
            end
            ST_MREAD: begin
                raw.mem_rd   = 1'b1;
                raw.iord     = 1'b1;
                raw.mdr_load = mem_rdy;
            end
            ST_MWB: begin
                raw.reg_write  = 1'b1;
                raw.mem_to_reg = 1'b1;
            end
            ST_MWRITE: begin
                raw.mem_wr = 1'b1;
                raw.iord   = 1'b1;
            end
            ST_REXE: begin
                raw.alu_src_a   = 1'b1;
                raw.alu_op      = ALUOP_FUNCT;
                raw.aluout_load = 1'b1;
            end
            ST_RWB: begin
                raw.reg_write = 1'b1;
                raw.reg_dst   = 1'b1;
            end
            ST_BEQ: begin
                raw.alu_src_a = 1'b1;
                raw.alu_op    = ALUOP_SUB;
                raw.pc_source = PCSRC_ALUOUT;
                raw.pc_load   = zero;
            end
            ST_JMP: begin
                raw.pc_source = PCSRC_JUMP;
                raw.pc_load   = 1'b1;
            end
            ST_IEXE: begin
                raw.alu_src_a   = 1'b1;
                raw.alu_src_b   = SRCB_IMM;
                raw.aluout_load = 1'b1;
            end
            ST_IWB: begin
                raw.reg_write = 1'b1;
            end
            default: raw = '0;
        endcase
    end

    // Under reset the state is already FETCH; only its read request and +4
    // select survive so nothing downstream loads or writes mid-reset.
    always_comb begin
        ctrl = raw;
        if (rst) begin
            ctrl           = '0;
            ctrl.mem_rd    = raw.mem_rd;
            ctrl.alu_src_b = raw.alu_src_b;
        end
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU controller: state register and next-state logic; output
// decode lives in ctrl_decode.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic             cl,
    input  logic             cr,
    multi_cycle_ctrl_if.master bus
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl;

    always_ff @(posedge cl or posedge cr) begin
        if (cr) state_q <= ST_FETCH;
        else    state_q <= state_d;
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = bus.mem_rdy ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = ST_REXE;
                    OP_LW, OP_SW: state_d = ST_MADDR;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_J:         state_d = ST_JMP;
                    OP_ADDI:      state_d = ST_IEXE;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MADDR:  state_d = (bus.opcode == OP_SW) ? ST_MWRITE : ST_MREAD;
            ST_MREAD:  state_d = bus.mem_rdy ? ST_MWB : ST_MREAD;
            ST_MWRITE: state_d = bus.mem_rdy ? ST_FETCH : ST_MWRITE;
            ST_REXE:   state_d = ST_RWB;
            ST_IEXE:   state_d = ST_IWB;
            default:   state_d = ST_FETCH;
        endcase
    end

    ctrl_decode u_decode (
        .state   (state_q),
        .opcode  (bus.opcode),
        .mem_rdy (bus.mem_rdy),
        .zero    (bus.zero),
        .rst     (cr),
        .ctrl    (ctrl)
    );

    assign bus.pc_load     = ctrl.pc_load;
    assign bus.ir_load     = ctrl.ir_load;
    assign bus.mdr_load    = ctrl.mdr_load;
    assign bus.ab_load     = ctrl.ab_load;
    assign bus.aluout_load = ctrl.aluout_load;
    assign bus.IorD        = ctrl.iord;
    assign bus.mem_rd      = ctrl.mem_rd;
    assign bus.mem_wr      = ctrl.mem_wr;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.illegal     = ctrl.illegal;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: instruction-level reference plans,
// a latency/pulse-count vector table, a mid-instruction reset and random programs.
module tb_multi_cycle_ctrl;

    typedef struct packed {
        logic       pc_load;
        logic       ir_load;
        logic       mdr_load;
        logic       ab_load;
        logic       aluout_load;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic       rdy;
        logic [3:0] st;
        outs_t      o;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         fw;
        int         mw;
        int         exp_lat;
        int         exp_regwr;
        int         exp_pcload;
    } vec_t;

    logic cl = 1'b0;
    logic cr = 1'b1;
    int   errors = 0;
    int   checks = 0;
    cyc_t plan[$];

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .cl  (cl),
        .cr  (cr),
        .bus (bus)
    );

    always #5 cl = ~cl;

    function automatic outs_t dut_outs();
        outs_t o;
        o.pc_load     = bus.pc_load;
        o.ir_load     = bus.ir_load;
        o.mdr_load    = bus.mdr_load;
        o.ab_load     = bus.ab_load;
        o.aluout_load = bus.aluout_load;
        o.iord        = bus.IorD;
        o.mem_rd      = bus.mem_rd;
        o.mem_wr      = bus.mem_wr;
        o.reg_write   = bus.RegWrite;
        o.reg_dst     = bus.RegDst;
        o.mem_to_reg  = bus.MemtoReg;
        o.alu_src_a   = bus.ALUSrcA;
        o.alu_src_b   = bus.ALUSrcB;
        o.alu_op      = bus.ALUOp;
        o.pc_source   = bus.PCSource;
        o.illegal     = bus.illegal;
        return o;
    endfunction

    function automatic bit known_op(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    function automatic outs_t fetch_outs(input logic rdy);
        outs_t o = '0;
        o.mem_rd    = 1'b1;
        o.alu_src_b = 2'b01;
        o.ir_load   = rdy;
        o.pc_load   = rdy;
        return o;
    endfunction

    function automatic void push(input logic rdy, input int st, input outs_t o);
        cyc_t c;
        c.rdy = rdy;
        c.st  = 4'(st);
        c.o   = o;
        plan.push_back(c);
    endfunction

    // Expected cycle-by-cycle walk of one instruction, phase by phase.
    function automatic void build_plan(input logic [5:0] op, input logic z,
                                       input int fw, input int mw);
        outs_t o;
        plan.delete();
        for (int i = 0; i < fw; i++) push(1'b0, 0, fetch_outs(1'b0));
        push(1'b1, 0, fetch_outs(1'b1));
        o = '0; o.ab_load = 1; o.aluout_load = 1; o.alu_src_b = 2'b11;
        o.illegal = !known_op(op);
        push(1'b1, 1, o);
        case (op)
            6'h00: begin
                o = '0; o.alu_src_a = 1; o.alu_op = 2'b10; o.aluout_load = 1;
                push(1'b1, 6, o);
                o = '0; o.reg_write = 1; o.reg_dst = 1;
                push(1'b1, 7, o);
            end
            6'h23, 6'h2B: begin
                o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10; o.aluout_load = 1;
                push(1'b1, 2, o);
                if (op == 6'h23) begin
                    o = '0; o.mem_rd = 1; o.iord = 1;
                    for (int i = 0; i < mw; i++) push(1'b0, 3, o);
                    o.mdr_load = 1;
                    push(1'b1, 3, o);
                    o = '0; o.reg_write = 1; o.mem_to_reg = 1;
                    push(1'b1, 4, o);
                end else begin
                    o = '0; o.mem_wr = 1; o.iord = 1;
                    for (int i = 0; i < mw; i++) push(1'b0, 5, o);
                    push(1'b1, 5, o);
                end
            end
            6'h04: begin
                o = '0; o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01;
                o.pc_load = z;
                push(1'b1, 8, o);
            end
            6'h02: begin
                o = '0; o.pc_source = 2'b10; o.pc_load = 1;
                push(1'b1, 9, o);
            end
            6'h08: begin
                o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10; o.aluout_load = 1;
                push(1'b1, 10, o);
                o = '0; o.reg_write = 1;
                push(1'b1, 11, o);
            end
            default: ;
        endcase
    endfunction

    task automatic check_cycle(input string name, input int idx,
                               input logic [3:0] exp_st, input outs_t exp_o);
        outs_t got = dut_outs();
        checks++;
        if (bus.state !== exp_st || got !== exp_o) begin
            errors++;
            $display("FAIL %s cyc %0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                     name, idx, bus.state, got, exp_st, exp_o);
        end
    endtask

    // Starts at posedge+1 with the DUT in FETCH; ends the same way.
    task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                             input int fw, input int mw);
        build_plan(op, z, fw, mw);
        bus.opcode = op;
        bus.zero   = z;
        bus.funct  = 6'($urandom_range(0, 63));
        for (int i = 0; i < plan.size(); i++) begin
            bus.mem_rdy = plan[i].rdy;
            #1;
            check_cycle(name, i, plan[i].st, plan[i].o);
            @(posedge cl); #1;
        end
    endtask

    task automatic run_vector(input int n, input vec_t v);
        int  cyc = 0, fcnt = 0, mcnt = 0, rw = 0, pl = 0;
        bit  left = 0, done = 0;
        bus.opcode = v.op;
        bus.zero   = v.z;
        bus.funct  = 6'($urandom_range(0, 63));
        for (int k = 0; k < 60 && !done; k++) begin
            if (bus.state == 4'd0) begin
                bus.mem_rdy = (fcnt < v.fw) ? 1'b0 : 1'b1;
                if (fcnt < v.fw) fcnt++;
            end else if (bus.state == 4'd3 || bus.state == 4'd5) begin
                bus.mem_rdy = (mcnt < v.mw) ? 1'b0 : 1'b1;
                if (mcnt < v.mw) mcnt++;
            end else begin
                bus.mem_rdy = 1'b1;
            end
            #1;
            if (bus.RegWrite) rw++;
            if (bus.pc_load) pl++;
            if (bus.state != 4'd0) left = 1;
            cyc++;
            @(posedge cl); #1;
            if (left && bus.state == 4'd0) done = 1;
        end
        checks++;
        if (!done || cyc != v.exp_lat || rw != v.exp_regwr || pl != v.exp_pcload) begin
            errors++;
            $display("FAIL vec%0d op=%h: got lat=%0d regwr=%0d pcload=%0d done=%0d, expected lat=%0d regwr=%0d pcload=%0d",
                     n, v.op, cyc, rw, pl, done, v.exp_lat, v.exp_regwr, v.exp_pcload);
        end
    endtask

    vec_t vecs[8];

    initial begin
        outs_t rst_o;
        logic [5:0] rop;
        logic [5:0] ops[7];

        vecs[0] = '{6'h00, 1'b0, 0, 0, 4, 1, 1};
        vecs[1] = '{6'h23, 1'b0, 0, 2, 7, 1, 1};
        vecs[2] = '{6'h2B, 1'b0, 1, 1, 6, 0, 1};
        vecs[3] = '{6'h04, 1'b1, 0, 0, 3, 0, 2};
        vecs[4] = '{6'h04, 1'b0, 0, 0, 3, 0, 1};
        vecs[5] = '{6'h02, 1'b0, 2, 0, 5, 0, 2};
        vecs[6] = '{6'h08, 1'b0, 3, 0, 7, 1, 1};
        vecs[7] = '{6'h3F, 1'b0, 0, 0, 2, 0, 1};

        rst_o = '0;
        rst_o.mem_rd    = 1'b1;
        rst_o.alu_src_b = 2'b01;

        bus.opcode  = 6'h00;
        bus.funct   = 6'h20;
        bus.zero    = 1'b1;
        bus.mem_rdy = 1'b1;
        repeat (2) @(posedge cl);
        #1;
        check_cycle("reset", 0, 4'd0, rst_o);
        cr = 1'b0;

        run_instr("rtype", 6'h00, 1'b0, 0, 0);
        run_instr("lw_wait2", 6'h23, 1'b0, 0, 2);
        run_instr("beq_z1", 6'h04, 1'b1, 0, 0);
        run_instr("beq_z0", 6'h04, 1'b0, 0, 0);
        run_instr("fetch_wait3", 6'h02, 1'b0, 3, 0);
        run_instr("illegal", 6'h3F, 1'b0, 0, 0);
        run_instr("sw_wait1", 6'h2B, 1'b0, 1, 1);
        run_instr("addi", 6'h08, 1'b0, 0, 0);

        foreach (vecs[i]) run_vector(i, vecs[i]);

        // Reset while lw waits in MREAD: state drops at once, no write-back.
        bus.opcode  = 6'h23;
        bus.mem_rdy = 1'b1;
        repeat (3) begin @(posedge cl); #1; end
        bus.mem_rdy = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset_mread: got state=%0d, expected 3", bus.state);
        end
        cr = 1'b1;
        bus.mem_rdy = 1'b1;
        #1;
        check_cycle("reset_mid", 0, 4'd0, rst_o);
        for (int i = 1; i <= 3; i++) begin
            @(posedge cl); #2;
            check_cycle("reset_hold", i, 4'd0, rst_o);
        end
        @(posedge cl); #1;
        cr = 1'b0;
        run_instr("after_reset", 6'h00, 1'b0, 0, 0);

        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h00};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                rop = 6'($urandom_range(0, 63));
                while (known_op(rop)) rop = 6'($urandom_range(0, 63));
            end else begin
                rop = ops[$urandom_range(0, 5)];
            end
            run_instr("random", rop, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
